// File: rtl/key_disp_ctrl_if.sv
// Keypad-to-display bus: key strobe from the scanner in, display/result signals out.
interface key_disp_ctrl_if;
  logic [3:0]  key_num;
  logic        key_vld;
  logic [31:0] din;
  logic [7:0]  din_vld;
  logic [31:0] value;
  logic        done;
  logic        err;

  modport master (
    output key_num, key_vld,
    input  din, din_vld, value, done, err
  );

  modport slave (
    input  key_num, key_vld,
    output din, din_vld, value, done, err
  );
endinterface

// File: rtl/key_disp_ctrl.sv
// Keypad number entry with 8-digit display, backspace, clear and enter/lock.
// Optional cursor blink on the newest digit is compiled in with macro KEY_DISP_BLINK_EN.
module key_disp_ctrl #(
  parameter int unsigned BLINK_CYC = 32'd25000000
) (
  input logic        clk,
  input logic        rst_n,
  key_disp_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EDIT, FULL, LOCK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] din_q, din_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  dinVld_q, dinVld_d;
  logic [7:0]  digitMask;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        isDigit, isBksp, isClear, isEnter;

  assign isDigit = bus.key_vld && (bus.key_num <= 4'h9);
  assign isBksp  = bus.key_vld && (bus.key_num == 4'hA);
  assign isClear = bus.key_vld && (bus.key_num == 4'hB);
  assign isEnter = bus.key_vld && (bus.key_num == 4'hC);

  // Codes 0xD-0xF fall through every branch and leave everything untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    value_d = value_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (isDigit) begin
      if (state_q == IDLE || state_q == EDIT) begin
        din_d   = {din_q[27:0], bus.key_num};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd7) ? FULL : EDIT;
      end else begin
        err_d = 1'b1;
      end
    end else if (isBksp) begin
      if (state_q == EDIT || state_q == FULL) begin
        din_d   = {4'h0, din_q[31:4]};
        cnt_d   = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? IDLE : EDIT;
      end else begin
        err_d = 1'b1;
      end
    end else if (isClear) begin
      din_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (isEnter) begin
      if (state_q == EDIT || state_q == FULL) begin
        value_d = din_q;
        done_d  = 1'b1;
        state_d = LOCK;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Only the entered digits light up, so leading zeros stay blank.
  always_comb begin
    digitMask = '0;
    for (int i = 0; i < 8; i++) begin
      digitMask[i] = (4'(i) < cnt_d);
    end
  end

`ifdef KEY_DISP_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BlinkW-1:0] blinkCnt_q, blinkCnt_d;
  logic              blinkOn_q, blinkOn_d;
  logic              accepted, editing;

  assign accepted = (isDigit && (state_q == IDLE || state_q == EDIT)) ||
                    (isBksp  && (state_q == EDIT || state_q == FULL));
  assign editing  = (state_d == EDIT) || (state_d == FULL);

  // Each edit restarts the cursor fully lit; outside editing it stays lit.
  always_comb begin
    blinkCnt_d = blinkCnt_q;
    blinkOn_d  = blinkOn_q;
    if (accepted || !editing) begin
      blinkCnt_d = '0;
      blinkOn_d  = 1'b1;
    end else if (blinkCnt_q == BlinkW'(BLINK_CYC - 1)) begin
      blinkCnt_d = '0;
      blinkOn_d  = ~blinkOn_q;
    end else begin
      blinkCnt_d = blinkCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blinkCnt_q <= '0;
      blinkOn_q  <= 1'b1;
    end else begin
      blinkCnt_q <= blinkCnt_d;
      blinkOn_q  <= blinkOn_d;
    end
  end
`else
  // BLINK_CYC only sizes the blink counter, which this build leaves out.
  if (BLINK_CYC == 0) begin : g_no_blink
  end
`endif

  always_comb begin
    dinVld_d = digitMask;
`ifdef KEY_DISP_BLINK_EN
    if (editing) begin
      dinVld_d[0] = digitMask[0] & blinkOn_d;
    end
`endif
    if (state_q == LOCK && state_d == LOCK) begin
      dinVld_d = dinVld_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      din_q    <= '0;
      value_q  <= '0;
      dinVld_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      value_q  <= value_d;
      dinVld_q <= dinVld_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.din     = din_q;
  assign bus.din_vld = dinVld_q;
  assign bus.value   = value_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_key_disp_ctrl.sv
// Self-checking bench for key_disp_ctrl: directed vector table, corner sequences, random vs. model.
module tb_key_disp_ctrl;

  localparam int unsigned BLINK = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  key_disp_ctrl_if bus ();

  key_disp_ctrl #(.BLINK_CYC(BLINK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  key;
    logic [31:0] din;
    logic [7:0]  dinVld;
    logic [31:0] value;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs [0:22];

  // Reference model: entered digits, oldest first, plus a lock flag
  logic [3:0]  mDigits[$];
  logic        mLocked;
  logic [31:0] mValue;
  logic        mDone;
  logic        mErr;
  int          mSince;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] eDin, input logic [7:0] eVld,
                             input logic [31:0] eValue, input logic eDone, input logic eErr);
    compare({tag, ".din"},     bus.din,           eDin);
    compare({tag, ".din_vld"}, 32'(bus.din_vld),  32'(eVld));
    compare({tag, ".value"},   bus.value,         eValue);
    compare({tag, ".done"},    32'(bus.done),     32'(eDone));
    compare({tag, ".err"},     32'(bus.err),      32'(eErr));
  endtask

  // Drive one cycle of keypad input, then sample just after the clock edge.
  task automatic applyStimulus(input logic vld, input logic [3:0] key);
    @(negedge clk);
    bus.key_vld = vld;
    bus.key_num = key;
    @(posedge clk);
    #1;
    bus.key_vld = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset", 32'h0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mDigits.delete();
    mLocked = 1'b0;
    mValue  = '0;
    mSince  = 0;
  endtask

  function automatic logic [31:0] modelDin();
    logic [31:0] d;
    d = '0;
    foreach (mDigits[i]) d = (d << 4) | 32'(mDigits[i]);
    return d;
  endfunction

  function automatic logic [7:0] modelVld();
    logic [7:0] m;
    logic       editing;
    m = 8'((1 << mDigits.size()) - 1);
    editing = !mLocked && (mDigits.size() > 0);
`ifdef KEY_DISP_BLINK_EN
    if (editing && (((mSince / BLINK) % 2) != 0)) m[0] = 1'b0;
`else
    if (editing && mSince < 0) m = 8'h00;
`endif
    return m;
  endfunction

  task automatic modelStep(input logic vld, input logic [3:0] key);
    logic accepted;
    accepted = 1'b0;
    mDone = 1'b0;
    mErr  = 1'b0;
    if (vld) begin
      if (key <= 4'h9) begin
        if (!mLocked && mDigits.size() < 8) begin
          mDigits.push_back(key);
          accepted = 1'b1;
        end else mErr = 1'b1;
      end else if (key == 4'hA) begin
        if (!mLocked && mDigits.size() > 0) begin
          void'(mDigits.pop_back());
          accepted = 1'b1;
        end else mErr = 1'b1;
      end else if (key == 4'hB) begin
        mDigits.delete();
        mLocked = 1'b0;
      end else if (key == 4'hC) begin
        if (!mLocked && mDigits.size() > 0) begin
          mValue  = modelDin();
          mDone   = 1'b1;
          mLocked = 1'b1;
        end else mErr = 1'b1;
      end
    end
    if (accepted || mLocked || mDigits.size() == 0) mSince = 0;
    else mSince++;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    bus.key_vld = 1'b0;
    bus.key_num = 4'h0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("por", 32'h0, 8'h00, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs = '{
      '{1'b1, 4'h1, 32'h00000001, 8'h01, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h2, 32'h00000012, 8'h03, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h3, 32'h00000123, 8'h07, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h4, 32'h00001234, 8'h0F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h5, 32'h00012345, 8'h1F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h6, 32'h00123456, 8'h3F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h7, 32'h01234567, 8'h7F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h8, 32'h12345678, 8'hFF, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h9, 32'h12345678, 8'hFF, 32'h0,  1'b0, 1'b1},
      '{1'b1, 4'hA, 32'h01234567, 8'h7F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'hA, 32'h00123456, 8'h3F, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'hB, 32'h00000000, 8'h00, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'hC, 32'h00000000, 8'h00, 32'h0,  1'b0, 1'b1},
      '{1'b1, 4'hE, 32'h00000000, 8'h00, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'hA, 32'h00000000, 8'h00, 32'h0,  1'b0, 1'b1},
      '{1'b1, 4'h5, 32'h00000005, 8'h01, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'h8, 32'h00000058, 8'h03, 32'h0,  1'b0, 1'b0},
      '{1'b1, 4'hC, 32'h00000058, 8'h03, 32'h58, 1'b1, 1'b0},
      '{1'b1, 4'h3, 32'h00000058, 8'h03, 32'h58, 1'b0, 1'b1},
      '{1'b1, 4'hA, 32'h00000058, 8'h03, 32'h58, 1'b0, 1'b1},
      '{1'b1, 4'hC, 32'h00000058, 8'h03, 32'h58, 1'b0, 1'b1},
      '{1'b1, 4'hB, 32'h00000000, 8'h00, 32'h58, 1'b0, 1'b0},
      '{1'b0, 4'h0, 32'h00000000, 8'h00, 32'h58, 1'b0, 1'b0}
    };
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].vld, vecs[i].key);
      checkOutput($sformatf("vec%0d", i), vecs[i].din, vecs[i].dinVld,
                  vecs[i].value, vecs[i].done, vecs[i].err);
    end

    // Fill all eight digits, then backspace all the way down and once more
    doReset();
    for (int k = 1; k <= 8; k++) applyStimulus(1'b1, 4'(k));
    for (int k = 1; k <= 7; k++) applyStimulus(1'b1, 4'hA);
    checkOutput("bs7", 32'h00000001, 8'h01, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA);
    checkOutput("bs8", 32'h0, 8'h00, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA);
    checkOutput("bs9", 32'h0, 8'h00, 32'h0, 1'b0, 1'b1);

    // Reset in the middle of entry and in LOCK discards everything
    applyStimulus(1'b1, 4'h1);
    applyStimulus(1'b1, 4'h2);
    doReset();
    applyStimulus(1'b1, 4'h7);
    checkOutput("postrst", 32'h7, 8'h01, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hC);
    checkOutput("lockent", 32'h7, 8'h01, 32'h7, 1'b1, 1'b0);
    doReset();
    applyStimulus(1'b1, 4'h4);
    checkOutput("postlock", 32'h4, 8'h01, 32'h0, 1'b0, 1'b0);

`ifdef KEY_DISP_BLINK_EN
    doReset();
    applyStimulus(1'b1, 4'h5);
    checkOutput("blink0", 32'h5, 8'h01, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 4'h0);
      checkOutput($sformatf("blink%0d", k), 32'h5, ((k / 4) % 2 == 0) ? 8'h01 : 8'h00,
                  32'h0, 1'b0, 1'b0);
    end
    doReset();
`endif

    // Random traffic against the reference model, with occasional resets
    doReset();
    for (int n = 0; n < 600; n++) begin
      logic       vld;
      logic [3:0] key;
      vld = ($urandom_range(0, 3) != 0);
      key = 4'($urandom_range(0, 15));
      if (n % 150 == 149) doReset();
      applyStimulus(vld, key);
      modelStep(vld, key);
      checkOutput($sformatf("rnd%0d", n), modelDin(), modelVld(), mValue, mDone, mErr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_disp_ctrl.md
KEY_DISP_CTRL -- requirements
Module: key_disp_ctrl

Interface
REQ-001 SHALL have parameter BLINK_CYC, default 25000000, blink half-period in clk cycles (0.5 s at 50 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port key_num  input  4  key code from keypad scanner; sampled only when key_vld=1.
REQ-005 SHALL have port key_vld  input  1  one-cycle strobe; each high cycle counts as one press.
REQ-006 SHALL have port din  output  32  8 display nibbles; nibble 0 (bits 3:0) is rightmost and newest; drives display din.
REQ-007 SHALL have port din_vld  output  8  per-digit enable; drives display din_vld.
REQ-008 SHALL have port value  output  32  committed number, updated only on enter.
REQ-009 SHALL have port done  output  1  one-cycle pulse on accepted enter.
REQ-010 SHALL have port err  output  1  one-cycle pulse on any rejected key.

Function
REQ-011 SHALL decode keys: 0x0-0x9 digit, 0xA backspace, 0xB clear, 0xC enter; 0xD-0xF ignored with no err.
REQ-012 SHALL keep digit count cnt (0..8) and FSM states IDLE (cnt=0), EDIT (1..7), FULL (8), LOCK.
REQ-013 SHALL register all outputs; a key strobed in cycle N is reflected on outputs in cycle N+1.
REQ-014 SHALL on digit in IDLE/EDIT: din <= {din[27:0], key_num}, cnt+1; IDLE->EDIT, EDIT->FULL when cnt reaches 8.
REQ-015 SHALL on digit in FULL or LOCK: leave din/cnt unchanged, pulse err.
REQ-016 SHALL on backspace in EDIT/FULL: din <= {4'h0, din[31:4]}, cnt-1; FULL->EDIT, EDIT->IDLE when cnt reaches 0.
REQ-017 SHALL on backspace in IDLE or LOCK: no change, pulse err.
REQ-018 SHALL on clear in any state: din=0, cnt=0, state IDLE, value unchanged, no err.
REQ-019 SHALL on enter in EDIT/FULL: value <= din, pulse done, go LOCK; on enter in IDLE or LOCK: pulse err.
REQ-020 SHALL drive din_vld[i]=1 exactly for i<cnt (leading blanks suppressed); digit 0 with value 0 displays as 0.
REQ-021 SHALL hold din_vld and din unchanged in LOCK until clear.
REQ-022 SHALL never assert done and err in the same cycle.

Reset
REQ-023 SHALL on rst_n=0 immediately force din=0, din_vld=0, value=0, done=0, err=0, cnt=0, state IDLE, blink counter 0, blink phase on.
REQ-024 SHALL, on reset asserted mid-entry or in LOCK, discard all state; first key after release is processed normally.

Configuration
REQ-025 SHALL compile the cursor blink under macro KEY_DISP_BLINK_EN.
REQ-026 SHALL with KEY_DISP_BLINK_EN defined, in EDIT/FULL, toggle din_vld[0] every BLINK_CYC cycles; counter and phase (on) restart on each accepted digit or backspace; IDLE/LOCK steady.
REQ-027 SHALL without KEY_DISP_BLINK_EN, contain no blink counter; din_vld[0] follows REQ-020 only.

Verification (BLINK_CYC=4 in bench)
REQ-028 SHALL cover: after reset, keys 1,2,3,4 -> din=32'h00001234, din_vld=8'h0F, state EDIT, err=0.
REQ-029 SHALL cover: keys 1..8 then 9 -> din=32'h12345678, din_vld=8'hFF, err pulses once on key 9, din unchanged.
REQ-030 SHALL cover: from 32'h12345678, backspace x2 -> din=32'h00123456, din_vld=8'h3F; backspace x7 total from 8 digits -> after 8th, din=0, din_vld=0, 9th -> err.
REQ-031 SHALL cover: 5,8,enter -> value=32'h00000058, done one cycle, then digit 3 -> err, din unchanged; clear -> din=0, din_vld=0, value stays 32'h58.
REQ-032 SHALL cover: enter in IDLE -> err, no done; key 0xE -> no change, no err.
REQ-033 SHALL cover: with KEY_DISP_BLINK_EN, one digit entered -> din_vld toggles 8'h01/8'h00 every 4 cycles; rst_n low mid-blink -> outputs 0 immediately.
